// File: rtl/adc_scan_seq.sv
// ADC scan sequencer: on each trigger, oversamples every listed channel,
// averages the samples, and publishes the whole frame with a one-cycle valid pulse.
module adc_scan_seq #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_ADDRS = {7'h1F, 7'h1E, 7'h17}
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     trigger_i,
  output logic [ADDR_W-1:0]        adc_addr_o,
  output logic                     adc_convst_o,
  input  logic                     adc_drdy_i,
  input  logic [DATA_W-1:0]        adc_data_i,
  output logic [NUM_CH*DATA_W-1:0] sample_o,
  output logic                     sample_valid_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic                     overrun_o,
  input  logic                     clr_err_i
);

  localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SAMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);

  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT, NEXT, DONE} state_t;

  state_t              state;
  logic [CH_W-1:0]     ch_idx;
  logic [CH_W-1:0]     ch_nxt;
  logic [SAMP_W-1:0]   samp_cnt;
  logic [TMO_W-1:0]    wait_cnt;
  logic [ACC_W-1:0]    acc;
  logic [DATA_W-1:0]   shadow [NUM_CH];
  logic [ADDR_W-1:0]   addr_tab [NUM_CH];

  // Unpack the channel address list into a lookup table.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      addr_tab[k] = CH_ADDRS[k*ADDR_W +: ADDR_W];
    end
  end

  assign ch_nxt = ch_idx + CH_W'(1);

  // Sequencer; sticky-flag clears come first so a coincident set overrides them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      ch_idx         <= '0;
      samp_cnt       <= '0;
      wait_cnt       <= '0;
      acc            <= '0;
      adc_addr_o     <= addr_tab[0];
      adc_convst_o   <= 1'b0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      timeout_o      <= 1'b0;
      overrun_o      <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      adc_convst_o   <= 1'b0;
      sample_valid_o <= 1'b0;
      if (clr_err_i) begin
        timeout_o <= 1'b0;
        overrun_o <= 1'b0;
      end
      if (trigger_i && (state != IDLE)) begin
        overrun_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trigger_i) begin
            state        <= CONV;
            ch_idx       <= '0;
            samp_cnt     <= '0;
            acc          <= '0;
            adc_addr_o   <= addr_tab[0];
            adc_convst_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        CONV: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (adc_drdy_i) begin
            acc   <= acc + ACC_W'(adc_data_i);
            state <= NEXT;
          end else if (wait_cnt == TMO_LAST) begin
            // Abort: previous frame stays on sample_o, no valid pulse.
            timeout_o  <= 1'b1;
            busy_o     <= 1'b0;
            adc_addr_o <= addr_tab[0];
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        NEXT: begin
          if (samp_cnt != SAMP_LAST) begin
            samp_cnt     <= samp_cnt + SAMP_W'(1);
            adc_convst_o <= 1'b1;
            state        <= CONV;
          end else begin
            shadow[ch_idx] <= DATA_W'(acc >> AVG_LOG2);
            acc            <= '0;
            samp_cnt       <= '0;
            if (ch_idx == CH_LAST) begin
              state <= DONE;
            end else begin
              ch_idx       <= ch_nxt;
              adc_addr_o   <= addr_tab[ch_nxt];
              adc_convst_o <= 1'b1;
              state        <= CONV;
            end
          end
        end
        DONE: begin
          for (int k = 0; k < NUM_CH; k++) begin
            sample_o[k*DATA_W +: DATA_W] <= shadow[k];
          end
          sample_valid_o <= 1'b1;
          busy_o         <= 1'b0;
          adc_addr_o     <= addr_tab[0];
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_seq.sv
// Self-checking bench for adc_scan_seq: randomized ADC responses checked
// against a frame-level averaging model built from the observed conversion log.
`timescale 1ns/1ps
module tb_adc_scan_seq;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned TMO      = 16;
  localparam int unsigned SAMP     = 1 << AVG_LOG2;
  localparam int unsigned NCONV    = NUM_CH * SAMP;
  localparam int unsigned FW       = NUM_CH * DATA_W;
  localparam int unsigned LAT      = 3 * NCONV + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              trigger = 1'b0;
  logic              clr_err = 1'b0;
  logic              adc_drdy;
  logic [DATA_W-1:0] adc_data;
  logic [ADDR_W-1:0] adc_addr;
  logic              adc_convst;
  logic [FW-1:0]     sample;
  logic              sample_valid, busy, timeout, overrun;

  logic [ADDR_W-1:0] exp_addr [NUM_CH] = '{7'h17, 7'h1E, 7'h1F};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int valid_cnt = 0;
  int last_convst = 0;
  logic [FW-1:0] last_frame = '0;

  // ADC model scripting and conversion log
  logic [DATA_W-1:0] rsp_data [$];
  int                rsp_dly [$];
  logic [ADDR_W-1:0] conv_addr [$];
  logic [DATA_W-1:0] conv_data [$];
  bit                pend = 0;
  bit                fired = 0;
  int                pend_wait = 0;
  logic [DATA_W-1:0] pend_data = '0;

  adc_scan_seq #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AVG_LOG2(AVG_LOG2),
    .TIMEOUT_CYC(TMO), .CH_ADDRS({7'h1F, 7'h1E, 7'h17})
  ) dut (
    .clk_i(clk), .rst_i(rst), .trigger_i(trigger),
    .adc_addr_o(adc_addr), .adc_convst_o(adc_convst),
    .adc_drdy_i(adc_drdy), .adc_data_i(adc_data),
    .sample_o(sample), .sample_valid_o(sample_valid),
    .busy_o(busy), .timeout_o(timeout), .overrun_o(overrun),
    .clr_err_i(clr_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Valid-pulse and convst monitor
  initial forever begin
    @(negedge clk);
    if (sample_valid === 1'b1) valid_cnt++;
    if (adc_convst === 1'b1) last_convst = cyc;
  end

  // ADC model: answers each convst after a scripted delay (-1 = never)
  initial begin
    adc_drdy = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (fired) begin adc_drdy = 1'b0; fired = 0; end
      if (pend) begin
        if (pend_wait == 0) begin
          adc_drdy = 1'b1;
          adc_data = pend_data;
          fired = 1;
          pend = 0;
          conv_data.push_back(pend_data);
        end else begin
          pend_wait--;
        end
      end
      if (adc_convst === 1'b1) begin
        int d;
        logic [DATA_W-1:0] v;
        conv_addr.push_back(adc_addr);
        if (rsp_dly.size() > 0) begin
          d = rsp_dly.pop_front();
          v = rsp_data.pop_front();
        end else begin
          d = 0;
          v = DATA_W'($urandom);
        end
        if (d >= 0) begin pend = 1; pend_wait = d; pend_data = v; end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: each channel result is the integer mean of its logged samples.
  function automatic logic [FW-1:0] ref_frame();
    logic [FW-1:0] f;
    int unsigned sum;
    f = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum = 0;
      for (int s = 0; s < SAMP; s++) sum += int'(conv_data[ch*SAMP + s]);
      f[ch*DATA_W +: DATA_W] = DATA_W'(sum / SAMP);
    end
    return f;
  endfunction

  task automatic clear_q();
    rsp_data.delete(); rsp_dly.delete(); conv_addr.delete(); conv_data.delete();
  endtask

  task automatic pulse_trigger();
    @(negedge clk);
    trigger = 1'b1;
    trig_cyc = cyc;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_in_reset got %0b exp 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (adc_convst !== 1'b0) begin errors++; $display("FAIL rst_convst got %0b exp 0", adc_convst); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %0b exp 0", overrun); end
    checks++; if (sample !== '0) begin errors++; $display("FAIL rst_sample got %h exp 0", sample); end
    checks++; if (adc_addr !== 7'h17) begin errors++; $display("FAIL rst_addr got %h exp 17", adc_addr); end
  endtask

  task automatic test_averaging();
    logic [FW-1:0] exp;
    bit seen;
    int v0;
    clear_q();
    for (int i = 0; i < SAMP; i++) begin rsp_data.push_back(DATA_W'(100 + i)); rsp_dly.push_back(0); end
    for (int i = 0; i < SAMP; i++) begin rsp_data.push_back(16'hFFFF); rsp_dly.push_back(0); end
    for (int i = 0; i < SAMP; i++) begin rsp_data.push_back(16'h3333); rsp_dly.push_back(0); end
    v0 = valid_cnt;
    pulse_trigger();
    checks++; if (adc_convst !== 1'b1) begin errors++; $display("FAIL avg_first_convst got %0b exp 1", adc_convst); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL avg_busy_start got %0b exp 1", busy); end
    wait_valid(300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL avg_valid_seen got 0 exp 1"); end
    checks++; if (cyc - trig_cyc != LAT) begin errors++; $display("FAIL avg_latency got %0d exp %0d", cyc - trig_cyc, LAT); end
    exp = {16'h3333, 16'hFFFF, 16'd101};
    checks++; if (sample !== exp) begin errors++; $display("FAIL avg_sample got %h exp %h", sample, exp); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL avg_busy_after got %0b exp 0", busy); end
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL avg_valid_count got %0d exp 1", valid_cnt - v0); end
    checks++; if (conv_addr.size() != NCONV) begin errors++; $display("FAIL avg_conv_count got %0d exp %0d", conv_addr.size(), NCONV); end
    for (int i = 0; i < conv_addr.size(); i++) begin
      checks++;
      if (conv_addr[i] !== exp_addr[i/SAMP]) begin
        errors++; $display("FAIL addr_seq[%0d] got %h exp %h", i, conv_addr[i], exp_addr[i/SAMP]);
      end
    end
    last_frame = exp;
  endtask

  task automatic test_random_frames();
    logic [FW-1:0] exp;
    bit seen, bad;
    int v0;
    for (int f = 0; f < 4; f++) begin
      clear_q();
      for (int i = 0; i < NCONV; i++) begin
        rsp_data.push_back(DATA_W'($urandom));
        rsp_dly.push_back(int'($urandom_range(0, 4)));
      end
      v0 = valid_cnt;
      pulse_trigger();
      wait_valid(400, seen);
      checks++; if (!seen) begin errors++; $display("FAIL rand%0d_valid_seen got 0 exp 1", f); end
      exp = ref_frame();
      checks++; if (sample !== exp) begin errors++; $display("FAIL rand%0d_sample got %h exp %h", f, sample, exp); end
      @(negedge clk);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL rand%0d_valid_count got %0d exp 1", f, valid_cnt - v0); end
      bad = (conv_data.size() != NCONV);
      for (int i = 0; i < conv_addr.size(); i++) if (conv_addr[i] !== exp_addr[i/SAMP]) bad = 1;
      checks++; if (bad) begin errors++; $display("FAIL rand%0d_conv_log got %0d convs, addr order wrong or short, exp %0d", f, conv_data.size(), NCONV); end
      last_frame = exp;
    end
  endtask

  task automatic test_timeout();
    logic [FW-1:0] prev, exp;
    bit seen;
    int v0;
    prev = last_frame;
    clear_q();
    for (int i = 0; i < SAMP; i++) begin rsp_data.push_back(DATA_W'($urandom)); rsp_dly.push_back(0); end
    rsp_data.push_back('0); rsp_dly.push_back(-1);
    v0 = valid_cnt;
    pulse_trigger();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL tmo_seen got 0 exp 1"); end
    checks++; if (cyc - last_convst != TMO + 1) begin errors++; $display("FAIL tmo_delay got %0d exp %0d", cyc - last_convst, TMO + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %0b exp 0", busy); end
    checks++; if (conv_addr.size() != SAMP + 1 || conv_addr[SAMP] !== exp_addr[1]) begin
      errors++; $display("FAIL tmo_conv_log got %0d convs, exp %0d ending on ch1", conv_addr.size(), SAMP + 1);
    end
    repeat (3) @(negedge clk);
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL tmo_no_valid got %0d exp 0", valid_cnt - v0); end
    checks++; if (sample !== prev) begin errors++; $display("FAIL tmo_sample_kept got %h exp %h", sample, prev); end
    clear_q();
    pulse_trigger();
    wait_valid(300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL tmo_recover_valid got 0 exp 1"); end
    exp = ref_frame();
    checks++; if (sample !== exp) begin errors++; $display("FAIL tmo_recover_sample got %h exp %h", sample, exp); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0b exp 1", timeout); end
    last_frame = exp;
  endtask

  task automatic test_overrun();
    logic [FW-1:0] exp;
    bit seen;
    int v0;
    clear_q();
    v0 = valid_cnt;
    pulse_trigger();
    repeat (10) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b exp 1", overrun); end
    wait_valid(300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL ovr_valid_seen got 0 exp 1"); end
    checks++; if (cyc - trig_cyc != LAT) begin errors++; $display("FAIL ovr_latency got %0d exp %0d", cyc - trig_cyc, LAT); end
    exp = ref_frame();
    checks++; if (sample !== exp) begin errors++; $display("FAIL ovr_sample got %h exp %h", sample, exp); end
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 != 1 || conv_addr.size() != NCONV) begin
      errors++; $display("FAIL ovr_single_frame got %0d valids %0d convs exp 1 and %0d", valid_cnt - v0, conv_addr.size(), NCONV);
    end
    clear_q();
    pulse_trigger();
    repeat (6) @(negedge clk);
    trigger = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    clr_err = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %0b exp 1", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL clr_timeout got %0b exp 0", timeout); end
    wait_valid(300, seen);
    exp = ref_frame();
    checks++; if (sample !== exp) begin errors++; $display("FAIL ovr2_sample got %h exp %h", sample, exp); end
    last_frame = exp;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got %0b exp 0", overrun); end
  endtask

  task automatic test_reset_mid();
    int v0;
    clear_q();
    for (int i = 0; i < 2*SAMP; i++) begin rsp_data.push_back(DATA_W'($urandom)); rsp_dly.push_back(0); end
    rsp_data.push_back('0); rsp_dly.push_back(-1);
    v0 = valid_cnt;
    pulse_trigger();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (conv_addr.size() >= 2*SAMP + 1) break;
    end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1 || adc_addr !== exp_addr[2]) begin
      errors++; $display("FAIL rstmid_pre busy %0b addr %h exp 1 and %h", busy, adc_addr, exp_addr[2]);
    end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b exp 0", busy); end
    checks++; if (sample !== '0) begin errors++; $display("FAIL rstmid_sample got %h exp 0", sample); end
    checks++; if (adc_addr !== 7'h17) begin errors++; $display("FAIL rstmid_addr got %h exp 17", adc_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pend = 0;
    @(negedge clk);
    adc_drdy = 1'b1;
    adc_data = 16'hABCD;
    @(negedge clk);
    adc_drdy = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || adc_convst !== 1'b0) begin errors++; $display("FAIL rstmid_stray_drdy busy %0b convst %0b exp 0 0", busy, adc_convst); end
    checks++; if (sample !== '0) begin errors++; $display("FAIL rstmid_sample_after got %h exp 0", sample); end
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", valid_cnt - v0); end
    last_frame = '0;
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] exp;
    bit seen;
    clear_q();
    pulse_trigger();
    wait_valid(300, seen);
    exp = ref_frame();
    checks++; if (sample !== exp) begin errors++; $display("FAIL b2b_first_sample got %h exp %h", sample, exp); end
    trigger = 1'b1;
    trig_cyc = cyc;
    clear_q();
    @(negedge clk);
    trigger = 1'b0;
    checks++; if (adc_convst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept convst %0b busy %0b exp 1 1", adc_convst, busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %0b exp 0", overrun); end
    wait_valid(300, seen);
    checks++; if (cyc - trig_cyc != LAT) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", cyc - trig_cyc, LAT); end
    exp = ref_frame();
    checks++; if (sample !== exp) begin errors++; $display("FAIL b2b_second_sample got %h exp %h", sample, exp); end
  endtask

  initial begin
    test_reset();
    test_averaging();
    test_random_frames();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_seq.md
# adc_scan_seq

Parametrised ADC scan sequencer for the 3LFCC control path. On each trigger it walks a configurable list of ADC channel addresses and issues one conversion start per sample. It oversamples each channel 2^AVG_LOG2 times and averages the results. All channel results are published atomically as one frame with a valid pulse. It sits between the conversion-trigger source (timer/PWM ADC trigger) and the voltage-calculation logic, replacing the fixed 3-channel capture sequencer.

## Interface
- NUM_CH, 3: number of channels scanned per frame (1..8)
- DATA_W, 16: ADC result width
- ADDR_W, 7: ADC channel address width
- AVG_LOG2, 2: log2 of samples averaged per channel (0..4)
- TIMEOUT_CYC, 1024: max cycles waiting for adc_drdy_i per conversion (≥2)
- CH_ADDRS, {7'h1F,7'h1E,7'h17}: packed NUM_CH*ADDR_W address list; channel k at bits [k*ADDR_W +: ADDR_W]
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- trigger_i  in  1  start-of-frame pulse
- adc_addr_o  out  ADDR_W  channel address presented to ADC
- adc_convst_o  out  1  one-cycle conversion-start pulse
- adc_drdy_i  in  1  ADC data-ready strobe (one cycle)
- adc_data_i  in  DATA_W  ADC result, valid when adc_drdy_i=1
- sample_o  out  NUM_CH*DATA_W  averaged frame, channel k at [k*DATA_W +: DATA_W]
- sample_valid_o  out  1  one-cycle pulse: new frame on sample_o
- busy_o  out  1  high while a frame is in progress
- timeout_o  out  1  sticky: a conversion timed out
- overrun_o  out  1  sticky: trigger_i arrived while busy
- clr_err_i  in  1  clears timeout_o and overrun_o

## Operation
- States: IDLE, CONV, WAIT, NEXT, DONE.
- IDLE: on trigger_i go to CONV; ch_idx=0, samp_cnt=0, acc=0. adc_drdy_i is ignored.
- CONV: adc_convst_o=1 for this single cycle; clear wait counter; go to WAIT.
- WAIT:
  - adc_drdy_i=1: acc += adc_data_i (width DATA_W+AVG_LOG2, no overflow possible); go to NEXT.
  - Wait counter reaches TIMEOUT_CYC-1 without drdy: set timeout_o; abort the frame. sample_o keeps the previous frame and no sample_valid_o pulse is issued. Go to IDLE.
- NEXT:
  - samp_cnt < 2^AVG_LOG2-1: samp_cnt++; go to CONV (same channel).
  - Otherwise: shadow[ch_idx] = acc >> AVG_LOG2 (truncating); acc=0; samp_cnt=0.
    - ch_idx == NUM_CH-1: go to DONE.
    - Else: ch_idx++; go to CONV.
- DONE: copy all shadow registers to sample_o in one edge; pulse sample_valid_o; go to IDLE.
- adc_addr_o = CH_ADDRS slot ch_idx, registered. It is stable from CONV through NEXT of each conversion. In IDLE it holds channel 0.
- busy_o = (state != IDLE).
- trigger_i while state != IDLE: ignored, and overrun_o is set. trigger_i in IDLE is always accepted.
- clr_err_i clears both sticky flags. If clr_err_i coincides with a new set event, the set wins.
- adc_drdy_i outside WAIT is ignored, including a drdy in the CONV cycle.

## Timing
- Reset values: adc_convst_o=0, sample_valid_o=0, busy_o=0, timeout_o=0, overrun_o=0, sample_o=0, adc_addr_o=CH_ADDRS slot 0; state IDLE.
- trigger_i high at edge T → adc_convst_o high in cycle T+1; busy_o high from T+1.
- Minimum conversion (drdy in first WAIT cycle) = 3 cycles: CONV, WAIT, NEXT.
- Minimum frame latency from trigger to sample_valid_o = 3·NUM_CH·2^AVG_LOG2 + 2 cycles. Defaults: 3·3·4+2 = 38.
- sample_valid_o and the new sample_o appear in the same cycle; busy_o is low in the following cycle.
- Timeout: adc_convst_o pulse at cycle C with no drdy → timeout_o high at C+TIMEOUT_CYC+1 and busy_o low in the same cycle.
- rst_i mid-frame: immediate return to IDLE; all outputs go to reset values, including clearing sample_o.

## Test plan
- Basic frame (AVG_LOG2=0, NUM_CH=3): ADC model returns 0x1111/0x2222/0x3333 for addrs 17h/1Eh/1Fh, one cycle after convst → sample_o = {3333,2222,1111}; one valid pulse; latency 11 cycles.
- Averaging (defaults): ch0 returns 100,101,102,103 → sample_o[0]=101 (sum 406 >>2); 0xFFFF ×4 → 0xFFFF with no overflow.
- Timeout (TIMEOUT_CYC=16): drdy withheld on ch1 → timeout_o rises 17 cycles after convst; no valid pulse; sample_o unchanged; next trigger produces a full frame normally.
- Overrun: trigger_i pulsed mid-frame → overrun_o=1, frame completes unchanged with one valid pulse; clr_err_i → both flags 0.
- Reset mid-frame: rst_i asserted during WAIT of ch2 → busy_o=0, sample_o=0, no valid pulse; stray drdy afterwards ignored.
- Address sequencing: check adc_addr_o = 17h,17h,17h,17h,1Eh×4,1Fh×4 across convst pulses with defaults.
